// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial bit-sequence detector.
// Accepts x_in when x_valid is high, compares the most recent PAT_LEN bits
// against a runtime-loadable pattern and raises a registered one-cycle
// detect pulse and a saturating match count.
// Optional feature (macro SEQ_DET_MASK_EN): per-bit don't-care mask loaded
// alongside the pattern.
module seq_detector_param #(
  parameter int unsigned        PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10111,
  parameter int unsigned        OVERLAP = 1,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x_valid,
  input  logic               x_in,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_LEN-1:0] pat_mask_in,
`endif
  input  logic               clr_cnt,
  output logic               detect,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  localparam int unsigned     FW        = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]   FILL_FULL = FW'(PAT_LEN);
  localparam logic [FW-1:0]   FILL_ARM  = FW'(PAT_LEN - 1);

  // Only the newest PAT_LEN-1 history bits can ever reach a compare, so the
  // oldest bit of the PAT_LEN-bit shift register is not stored.
  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [PAT_LEN-1:0] pat_reg;
  logic [PAT_LEN-1:0] shifted;
  logic [PAT_LEN-1:0] care;
  logic               match;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_LEN-1:0] mask_reg;
`endif

  // Candidate window and match qualification for the bit presented this cycle.
  always_comb begin
    shifted = {hist, x_in};
`ifdef SEQ_DET_MASK_EN
    care    = ~mask_reg;
`else
    care    = '1;
`endif
    match   = x_valid && !pat_load && (fill >= FILL_ARM) &&
              (((shifted ^ pat_reg) & care) == '0);
  end

  assign armed = (fill == FILL_FULL);

  // History, fill, pattern, detect pulse and match counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pat_reg   <= PATTERN;
`ifdef SEQ_DET_MASK_EN
      mask_reg  <= '0;
`endif
      detect    <= 1'b0;
      match_cnt <= '0;
    end else begin
      detect <= match;
      if (pat_load) begin
        pat_reg <= pat_in;
`ifdef SEQ_DET_MASK_EN
        mask_reg <= pat_mask_in;
`endif
        hist    <= '0;
        fill    <= '0;
      end else if (x_valid) begin
        hist <= shifted[PAT_LEN-2:0];
        if (match && (OVERLAP == 0))
          fill <= '0;
        else if (fill != FILL_FULL)
          fill <= fill + 1'b1;
      end
      if (clr_cnt)
        match_cnt <= match ? CNT_W'(1) : '0;
      else if (match && (match_cnt != '1))
        match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed testbench for seq_detector_param. Three instances share stimulus:
// default parameters, OVERLAP=0, and CNT_W=2 for counter saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       x_valid;
  logic       x_in;
  logic       pat_load;
  logic [4:0] pat_in;
  logic       clr_cnt;
`ifdef SEQ_DET_MASK_EN
  logic [4:0] pat_mask_in;
`endif

  logic       det_d, det_n, det_s;
  logic [7:0] cnt_d, cnt_n;
  logic [1:0] cnt_s;
  logic       arm_d, arm_n, arm_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_detector_param u_dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .clr_cnt(clr_cnt), .detect(det_d), .match_cnt(cnt_d), .armed(arm_d)
  );

  seq_detector_param #(.OVERLAP(0)) u_nov (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .clr_cnt(clr_cnt), .detect(det_n), .match_cnt(cnt_n), .armed(arm_n)
  );

  seq_detector_param #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .clr_cnt(clr_cnt), .detect(det_s), .match_cnt(cnt_s), .armed(arm_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    x_valid = 1'b1;
    x_in    = b;
    step();
    x_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load_pat(input logic [4:0] p, input logic [4:0] m);
    pat_load = 1'b1;
    pat_in   = p;
`ifdef SEQ_DET_MASK_EN
    pat_mask_in = m;
`else
    if (m != 5'b0) $display("[TB] mask ignored in this build");
`endif
    step();
    pat_load = 1'b0;
  endtask

  // Send n bits (MSB first) and check detect after each against the
  // expected pulse maps of the overlapping and non-overlapping instances.
  task automatic send_chk(input string tag, input logic [15:0] bits, input int n,
                          input logic [15:0] exp_d, input logic [15:0] exp_n);
    for (int i = 0; i < n; i++) begin
      bit_in(bits[n-1-i]);
      chk($sformatf("%s.det[%0d]", tag, i), 32'(det_d), 32'(exp_d[n-1-i]));
      chk($sformatf("%s.detnov[%0d]", tag, i), 32'(det_n), 32'(exp_n[n-1-i]));
    end
  endtask

  initial begin
    rst = 1'b1; x_valid = 1'b0; x_in = 1'b0; pat_load = 1'b0;
    pat_in = '0; clr_cnt = 1'b0;
`ifdef SEQ_DET_MASK_EN
    pat_mask_in = '0;
`endif
    #2;
    chk("rst.detect", 32'(det_d), 0);
    chk("rst.cnt", 32'(cnt_d), 0);
    chk("rst.armed", 32'(arm_d), 0);
    step();
    step();
    rst = 1'b0;

    // 1: default pattern 10111, consecutive bits
    send_chk("t1", 16'b1011, 4, 16'b0000, 16'b0000);
    chk("t1.armed4", 32'(arm_d), 0);
    send_chk("t1b", 16'b1, 1, 16'b1, 16'b1);
    chk("t1.armed5", 32'(arm_d), 1);
    chk("t1.cnt", 32'(cnt_d), 1);
    step();
    chk("t1.detect_drop", 32'(det_d), 0);

    // 2: load 10101, stream 1010101, overlap vs non-overlap
    do_reset();
    load_pat(5'b10101, 5'b0);
    chk("t2.armed_after_load", 32'(arm_d), 0);
    send_chk("t2", 16'b1010101, 7, 16'b0000101, 16'b0000100);
    chk("t2.cnt_ov", 32'(cnt_d), 2);
    chk("t2.cnt_nov", 32'(cnt_n), 1);

    // 3: gaps of x_valid=0 between every bit (default pattern after reset)
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [4:0] pat;
      pat = 5'b10111;
      bit_in(pat[4-i]);
      chk($sformatf("t3.det[%0d]", i), 32'(det_d), (i == 4) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("t3.gap[%0d]", i), 32'(det_d), 0);
    end
    chk("t3.cnt", 32'(cnt_d), 1);

    // 4: reset mid-sequence loses history; outputs zero while rst high
    send_chk("t4a", 16'b101, 3, 16'b000, 16'b000);
    rst = 1'b1;
    #2;
    chk("t4.rst_cnt", 32'(cnt_d), 0);
    chk("t4.rst_armed", 32'(arm_d), 0);
    chk("t4.rst_detect", 32'(det_d), 0);
    step();
    rst = 1'b0;
    send_chk("t4b", 16'b11, 2, 16'b00, 16'b00);
    send_chk("t4c", 16'b10111, 5, 16'b00001, 16'b00001);

    // 5: saturation with CNT_W=2, then clr coincident with a match
    do_reset();
    for (int k = 0; k < 5; k++)
      send_chk($sformatf("t5.%0d", k), 16'b10111, 5, 16'b00001, 16'b00001);
    chk("t5.cnt_sat", 32'(cnt_s), 3);
    chk("t5.cnt_wide", 32'(cnt_d), 5);
    send_chk("t5.6", 16'b1011, 4, 16'b0000, 16'b0000);
    clr_cnt = 1'b1;
    bit_in(1'b1);
    clr_cnt = 1'b0;
    chk("t5.clr_match_det", 32'(det_s), 1);
    chk("t5.clr_match_sat", 32'(cnt_s), 1);
    chk("t5.clr_match_wide", 32'(cnt_d), 1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("t5.clr_alone", 32'(cnt_d), 0);

    // 6: pat_load wins over a simultaneous completing bit
    do_reset();
    send_chk("t6a", 16'b1011, 4, 16'b0000, 16'b0000);
    pat_load = 1'b1;
    pat_in   = 5'b10111;
`ifdef SEQ_DET_MASK_EN
    pat_mask_in = '0;
`endif
    x_valid = 1'b1;
    x_in    = 1'b1;
    step();
    pat_load = 1'b0;
    x_valid  = 1'b0;
    chk("t6.dropped_det", 32'(det_d), 0);
    chk("t6.dropped_armed", 32'(arm_d), 0);
    chk("t6.cnt_kept", 32'(cnt_d), 0);
    send_chk("t6b", 16'b1011, 4, 16'b0000, 16'b0000);
    chk("t6.fill4", 32'(arm_d), 0);
    send_chk("t6c", 16'b1, 1, 16'b1, 16'b1);
    chk("t6.armed", 32'(arm_d), 1);

`ifdef SEQ_DET_MASK_EN
    load_pat(5'b10111, 5'b00100);
    send_chk("t6m", 16'b10011, 5, 16'b00001, 16'b00001);
`else
    load_pat(5'b10111, 5'b00000);
    send_chk("t6x", 16'b10011, 5, 16'b00000, 16'b00000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
